// File: rtl/adc_spi_pkg.sv
// ============================================================================
//  adc_spi_pkg : shared types and helpers for the MCP3008-style SPI responder
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package adc_spi_pkg;

    localparam int CMD_BITS = 4;
    localparam int CH_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_CMD        = 3'd2,
        ST_NULL       = 3'd3,
        ST_DATA       = 3'd4,
        ST_TRAIL      = 3'd5
    } state_e;

    // Unsigned a - b, clamped at zero rather than wrapping.
    function automatic logic [31:0] diff_sat(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_in_sync.sv
// ============================================================================
//  spi_in_sync : multi-flop synchronizer with rise/fall pulse outputs
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

`default_nettype wire

// File: rtl/adc_spi_responder.sv
// ============================================================================
//  adc_spi_responder : SPI mode-0 emulation of an 8-channel 10-bit ADC
//  Revision          : 1.0
// ============================================================================
`default_nettype none

module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  sclk_i,
    input  logic                  ncs_i,
    input  logic                  mosi_i,
    input  logic [NCH*DATA_W-1:0] ch_data_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic                  cmd_valid_o,
    output logic                  cmd_single_o,
    output logic [CH_W-1:0]       cmd_chan_o,
    output logic                  frame_err_o,
    output logic                  busy_o
);

    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_ncs_s,  w_ncs_rise,  w_ncs_fall;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(sclk_i),
        .q_o(w_sclk_s), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(ncs_i),
        .q_o(w_ncs_s), .rise_o(w_ncs_rise), .fall_o(w_ncs_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(mosi_i),
        .q_o(w_mosi_s), .rise_o(w_mosi_rise), .fall_o(w_mosi_fall)
    );

    state_e              state_q;
    logic [CMD_BITS-1:0] cmd_sh_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [FLUSH_W-1:0]  flush_q;
    logic                armed_q;
    logic                miso_q, miso_oe_q, cmd_valid_q, cmd_single_q, frame_err_q, busy_q;
    logic [CH_W-1:0]     cmd_chan_q;

    // Channel and return word as they will be on the rise that captures D0.
    logic [CH_W-1:0]   w_chan;
    logic [DATA_W-1:0] w_sel, w_pair, w_diff, w_word;

    assign w_chan = {cmd_sh_q[1:0], w_mosi_s};
    assign w_sel  = ch_data_i[int'(w_chan) * DATA_W +: DATA_W];
    assign w_pair = ch_data_i[int'(w_chan ^ CH_W'(1)) * DATA_W +: DATA_W];
    assign w_diff = DATA_W'(diff_sat(32'(w_sel), 32'(w_pair)));
    assign w_word = cmd_sh_q[2] ? w_sel : w_diff;

    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_s, w_ncs_rise, w_ncs_fall, w_mosi_rise, w_mosi_fall, cmd_sh_q[3]};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cmd_sh_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            flush_q      <= '0;
            armed_q      <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_single_q <= 1'b0;
            cmd_chan_q   <= '0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;

            // A frame may only start after ncs has been seen high once the
            // synchronizer holds real pin data, so a reset with ncs held low
            // cannot resume or fake a frame.
            if (flush_q != FLUSH_W'(SYNC_STAGES)) begin
                flush_q <= flush_q + FLUSH_W'(1);
            end else if (w_ncs_s) begin
                armed_q <= 1'b1;
            end

            if (state_q != ST_IDLE && w_ncs_s) begin
                frame_err_q <= (state_q == ST_CMD) || (state_q == ST_NULL) ||
                               ((state_q == ST_DATA) && (bit_cnt_q != CNT_W'(DATA_W)));
                state_q     <= ST_IDLE;
                miso_q      <= 1'b0;
                miso_oe_q   <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (armed_q && !w_ncs_s) begin
                            busy_q    <= 1'b1;
                            miso_oe_q <= 1'b1;
                            miso_q    <= 1'b0;
                            state_q   <= ST_WAIT_START;
                        end
                    end
                    ST_WAIT_START: begin
                        if (w_sclk_rise && w_mosi_s) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            cmd_sh_q <= {cmd_sh_q[CMD_BITS-2:0], w_mosi_s};
                            if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                                cmd_single_q <= cmd_sh_q[2];
                                cmd_chan_q   <= w_chan;
                                shift_q      <= w_word;
                                cmd_valid_q  <= 1'b1;
                                bit_cnt_q    <= '0;
                                state_q      <= ST_NULL;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_NULL: begin
                        if (w_sclk_fall) begin
                            if (bit_cnt_q == '0) begin
                                miso_q    <= 1'b0;
                                bit_cnt_q <= CNT_W'(1);
                            end else begin
                                miso_q    <= shift_q[DATA_W-1];
                                shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
                                bit_cnt_q <= CNT_W'(1);
                                state_q   <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        // bit_cnt_q counts data bits already on miso.
                        if (w_sclk_fall) begin
                            if (bit_cnt_q == CNT_W'(DATA_W)) begin
                                miso_q  <= 1'b0;
                                state_q <= ST_TRAIL;
                            end else begin
                                miso_q    <= shift_q[DATA_W-1];
                                shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_TRAIL: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign miso_o       = miso_q;
    assign miso_oe_o    = miso_oe_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_single_o = cmd_single_q;
    assign cmd_chan_o   = cmd_chan_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = busy_q;

endmodule

`default_nettype wire

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- SPI mode-0 peripheral that emulates an 8-channel, 10-bit MCP3008-style ADC.
- Oversamples the external sclk/ncs/mosi in the system clock domain, decodes the start/SGL/D2..D0 command, and shifts the selected channel's 10-bit value out on miso MSB first.
- Serves as the far-end model for our SPI ADC reader in simulation and as an on-FPGA stand-in for the ADC, fed from parallel sample inputs.

Parameters:
DATA_W, 10, bits per sample returned.
NCH, 8, number of channels; the channel index is 3 bits.
SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input; minimum 2.

Ports:
clk  in  1  system clock; must be at least 8x the sclk frequency.
reset  in  1  asynchronous, active-high reset.
sclk  in  1  SPI clock from the initiator; idles low.
ncs  in  1  active-low chip select.
mosi  in  1  command bits, sampled on sclk rising edges.
ch_data  in  NCH*DATA_W  packed channel values; channel i occupies bits [i*DATA_W +: DATA_W].
miso  out  1  response bit, changes after sclk falling edges.
miso_oe  out  1  miso drive enable; 0 means high-Z at the pad.
cmd_valid  out  1  one-clk pulse when a command has been decoded.
cmd_single  out  1  SGL/DIFF bit of the last command; held.
cmd_chan  out  3  D2..D0 of the last command; held.
frame_err  out  1  one-clk pulse when ncs deasserts before B0 is driven.
busy  out  1  high while a frame is active (synchronized ncs low).

Behaviour:
- Reset values: miso=0, miso_oe=0, cmd_valid=0, cmd_single=0, cmd_chan=0, frame_err=0, busy=0, FSM=IDLE, all synchronizers 0 except ncs, which resets to 1.
- Input conditioning:
  - sclk, ncs and mosi each pass through SYNC_STAGES flops.
  - Rising and falling edges of sclk are detected on the synchronized signal as one-clk pulses.
  - Every decision below uses the synchronized values.
- FSM states and transitions:
  - IDLE: wait for ncs low. On ncs low, set busy=1, miso_oe=1, miso=0, and go to WAIT_START.
  - WAIT_START: on each sclk rise, if mosi=1 go to CMD with bit count 0. Leading zeros are ignored indefinitely.
  - CMD: on each sclk rise, shift mosi into a 4-bit register, first bit = SGL, then D2, D1, D0.
    - On the rise that captures D0: latch cmd_single and cmd_chan, snapshot ch_data[cmd_chan] into a DATA_W shift register, pulse cmd_valid on the following clk, and go to NULL.
  - NULL: on the next sclk fall, drive miso=0 (null bit). On the following sclk fall, drive B9 and go to DATA.
  - DATA: on each subsequent sclk fall, drive the next bit, MSB first.
    - After B0 has been driven, the next sclk fall drives 0 and moves to TRAIL.
  - TRAIL: miso held 0 and further sclk edges ignored until ncs rises.
- Response timing, counting sclk rises from ncs fall:
  - With the start bit on rise s, D0 is on rise s+4.
  - Null bit is valid at rise s+5.
  - B9 is valid at rise s+6, through B0 at rise s+15.
- ncs high from any state:
  - Next clk: FSM=IDLE, miso_oe=0, miso=0, busy=0.
  - If the state was CMD, NULL or DATA (i.e. B0 not yet driven), pulse frame_err once.
- Data coherence: ch_data changes after the snapshot do not affect the frame in progress.
- Simultaneous events:
  - ncs rise and an sclk edge detected in the same clk: ncs wins and the edge is dropped.
  - reset overrides everything asynchronously.
- Reset mid-frame: outputs return to their reset values immediately. The frame is not resumed; the responder waits for a fresh ncs high-to-low transition.
- Differential mode (cmd_single=0): same timing. Returned value is ch_data[cmd_chan] minus ch_data[cmd_chan^1], saturated at 0, DATA_W bits unsigned.

Decomposition:
- Package adc_spi_pkg:
  - state enum {IDLE, WAIT_START, CMD, NULL, DATA, TRAIL}.
  - CMD_BITS=4 and the channel-index width.
  - Helper function for differential saturation.
- Sub-module spi_in_sync: SYNC_STAGES synchronizer plus rise/fall pulse outputs, parameterized reset value. Instantiated three times.

Test Plan:
1. Reset release, ncs high, sclk toggling -> miso_oe=0, busy=0, no cmd_valid.
2. ch_data[2]=10'h2A5; mosi frame 0,1,1,0,1,0 then zeros, 17 sclk cycles, sclk = clk/32:
   - cmd_valid pulses once with cmd_single=1, cmd_chan=2.
   - Bits sampled on rises 7..16 are null(0) followed by 1,0,1,0,1,0,0,1,0 (B9..B1); B0=1 at rise 17.
3. ch_data[5] changed from 10'h3FF to 10'h000 one sclk after D0 -> returned word is 10'h3FF.
4. ncs raised after 3 data bits -> frame_err pulses once, miso_oe=0 next clk; a following full frame on channel 7 returns the correct value.
5. Differential, chan=0, ch0=10'h120, ch1=10'h020 -> returns 10'h100. Swapped values -> returns 10'h000.
6. reset asserted mid-DATA -> outputs go to reset values immediately; after release, no response until ncs goes high then low again.
